// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC sequencer: FSM encoding, operand/accumulator widths,
// and the partial-product generator that feeds the Dadda tree.
package mac_pkg;

  localparam int ACC_W = 16;
  localparam int OP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  // bit [OP_W*i+j] = a[i] & b[j], i.e. P[i][j] with weight i+j
  function automatic logic [OP_W*OP_W-1:0] pp_gen(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
    logic [OP_W*OP_W-1:0] pp;
    pp = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        pp[OP_W*i+j] = a[i] & b[j];
      end
    end
    return pp;
  endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Operand register + accumulator around the Dadda MAC tree; one beat/cycle, result 1 cycle after last beat.
// in_ready drops while the last beat retires and in DONE until out_ready; MAC_SAT_EN selects saturating accumulation.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_a,
  input  logic [OP_W-1:0]      in_b,
  input  logic                 in_last,
  output logic [OP_W*OP_W-1:0] pp_out,
  output logic [ACC_W-1:0]     acc_out,
  input  logic [ACC_W:0]       mac_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_ovf,
  output logic [CNT_W-1:0]     out_count
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       r_state;
  logic [OP_W-1:0]  r_a;
  logic [OP_W-1:0]  r_b;
  logic             r_last;
  logic             r_v;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_retire;
  logic             w_take;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_retire = (r_state == S_RUN) && r_v && r_last;
  // rst gates in_ready so the port reads 0 for as long as reset is held
  assign in_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_RUN) && !w_retire));
  assign w_take   = in_valid && in_ready;

`ifdef MAC_SAT_EN
  assign w_acc_nxt = (mac_in[ACC_W] || r_ovf) ? {ACC_W{1'b1}} : mac_in[ACC_W-1:0];
`else
  assign w_acc_nxt = mac_in[ACC_W-1:0];
`endif

  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_last  <= 1'b0;
      r_v     <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          r_ovf <= 1'b0;
          r_cnt <= '0;
          if (w_take) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_last  <= in_last;
            r_v     <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_v) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | mac_in[ACC_W];
            r_cnt <= w_cnt_nxt;
          end
          if (w_take) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_last <= in_last;
            r_v    <= 1'b1;
          end else begin
            r_v <= 1'b0;
          end
          if (w_retire) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // zero partial products on bubbles make the tree return acc unchanged
  assign pp_out    = r_v ? pp_gen(r_a, r_b) : '0;
  assign acc_out   = r_acc;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_mac_sequencer.sv
// Closed-loop bench: behavioural MAC tree on mac_in, burst-level reference model for the totals.
module tb_mac_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic [63:0]      pp_out;
  logic [15:0]      acc_out;
  logic [16:0]      mac_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned qa[$];
  int unsigned qb[$];

  always #5 clk = ~clk;

  mac_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .pp_out(pp_out),
    .acc_out(acc_out), .mac_in(mac_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .out_count(out_count)
  );

  // Stand-in for the Dadda tree: weighted popcount of P plus M
  logic [16:0] tree_sum;
  always_comb begin
    tree_sum = {1'b0, acc_out};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (pp_out[8*i+j]) tree_sum = tree_sum + (17'd1 << (i + j));
  end
  assign mac_in = tree_sum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives the burst in qa/qb, checks the result, holds DONE for 'hold' cycles, then releases it.
  task automatic run_burst(input string tag, input int hold, input bit gaps);
    int          n;
    int          idx;
    int          cyc;
    int          stalls;
    bit          took;
    longint      total;
    logic [31:0] exp_data;
    logic [31:0] exp_ovf;
    logic [31:0] exp_cnt;
    n = qa.size();
    idx = 0; cyc = 0; stalls = 0; total = 0;
    for (int k = 0; k < n; k++) total += longint'(qa[k]) * longint'(qb[k]);
    exp_ovf = (total >= 65536) ? 1 : 0;
`ifdef MAC_SAT_EN
    exp_data = exp_ovf[0] ? 32'd65535 : 32'(total);
`else
    exp_data = 32'(total % 65536);
`endif
    exp_cnt = (n > 255) ? 255 : n;

    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      if (gaps && idx > 0 && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        cyc++;
      end else begin
        in_valid = 1'b1;
        in_a     = qa[idx][7:0];
        in_b     = qb[idx][7:0];
        in_last  = (idx == n - 1);
        #1 took  = in_ready;
        @(posedge clk);
        cyc++;
        if (took) idx++;
        else stalls++;
      end
    end
    chk({tag, "_accepted"}, idx, n);
    if (!gaps) chk({tag, "_stalls"}, stalls, 0);

    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_vld_early"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_ovf"}, out_ovf, exp_ovf);
    chk({tag, "_count"}, out_count, exp_cnt);
    chk({tag, "_rdy_done"}, in_ready, 0);

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      @(negedge clk);
      chk({tag, "_hold_vld"}, out_valid, 1);
      chk({tag, "_hold_data"}, out_data, exp_data);
      chk({tag, "_hold_rdy"}, in_ready, 0);
    end

    // release with in_valid still high: that beat must not be taken
    in_valid  = 1'b1;
    in_a      = 8'hff;
    in_b      = 8'hff;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_rel_vld"}, out_valid, 0);
    chk({tag, "_rel_acc"}, acc_out, 0);
    chk({tag, "_rel_pp"}, (pp_out == 64'd0) ? 1 : 0, 1);
    chk({tag, "_rel_rdy"}, in_ready, 1);
    qa.delete();
    qb.delete();
  endtask

  task automatic push(input int unsigned a, input int unsigned b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_pp", (pp_out == 64'd0) ? 1 : 0, 1);
    chk("rst_cnt", out_count, 0);
    rst = 1'b0;
    @(negedge clk);

    push(3, 5);
    run_burst("single", 0, 1'b0);

    for (int k = 0; k < 4; k++) push(10, 10);
    run_burst("burst4", 0, 1'b0);

    push(255, 255); push(255, 255);
    run_burst("ovf", 1, 1'b0);

    push(6, 6);
    run_burst("held", 5, 1'b0);
    push(2, 2);
    run_burst("after_hold", 0, 1'b0);

    // reset after two of four beats
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd11; in_last = 1'b0;
    @(negedge clk);
    in_a = 8'd12; in_b = 8'd13;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_pp", (pp_out == 64'd0) ? 1 : 0, 1);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cnt", out_count, 0);
    rst = 1'b0;
    @(negedge clk);
    push(7, 9);
    run_burst("post_rst", 0, 1'b0);

    for (int k = 0; k < 300; k++) push(1, 1);
    run_burst("sat_cnt", 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int n;
      bit big;
      n = $urandom_range(8, 1);
      big = $urandom_range(1);
      for (int k = 0; k < n; k++) begin
        if (big) push($urandom_range(255, 200), $urandom_range(255, 200));
        else     push($urandom_range(255), $urandom_range(255));
      end
      run_burst($sformatf("rnd%0d", r), $urandom_range(3), $urandom_range(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
